prog_loader: RTL and testbench

- UART program loader: the writer side of the CPU's 16x8 instruction RAM, which the CPU reads at regs[7].
- Receives a framed 16-byte program image over a serial line and writes it into the RAM one byte at a time.
- Holds the CPU in reset for the whole transfer and releases it only when the checksum is correct.
- Sits at the top level between the board's UART RX pin and the CPU's RAM write port / rst input.

---
 rtl/prog_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`timescale 1ns/1ps
// prog_loader
// UART program loader for the CPU's 16x8 instruction RAM. Receives a frame
// of SYNC_BYTE, DEPTH program bytes and a mod-256 checksum over an 8N1 line,
// writes the program bytes into the RAM one at a time and keeps the CPU in
// reset until a frame arrives whose checksum matches.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-low
//   uart_rx    asynchronous serial input, 8N1, idle high
//   mem_we     RAM write strobe, one-cycle pulse
//   mem_addr   RAM write address (held between writes)
//   mem_wdata  RAM write data (held between writes)
//   cpu_rst    active-low CPU reset, 0 = CPU held
//   busy       frame in progress
//   done       last frame loaded OK, sticky until next sync byte
//   err        last frame failed, sticky until next sync byte
module prog_loader #(
    parameter int         CLKS_PER_BIT = 234,
    parameter int         DEPTH        = 16,
    parameter int         ADDR_W       = 4,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5,
    parameter int         TIMEOUT_BITS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TO_W     = $clog2(TO_LIMIT);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {L_SYNC, L_DATA, L_SUM} ld_state_t;

    logic rx_meta, rx_s, rx_prev;

    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err, frame_err_n;

    ld_state_t         ld_state, ld_state_n;
    logic [ADDR_W-1:0] index, index_n;
    logic [7:0]        sum, sum_n;
    logic [TO_W-1:0]   to_cnt, to_cnt_n;
    logic              hold, hold_n;
    logic              mem_we_n, busy_n, done_n, err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;

    // Two-flop synchronizer for the serial line, plus one extra stage so the
    // receiver can see a falling edge. All stages reset to the idle level so
    // leaving reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state   <= R_IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            clk_cnt    <= clk_cnt_n;
            bit_cnt    <= bit_cnt_n;
            shift      <= shift_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Receiver next-state logic. The start bit is re-checked half a bit in
    // so short low glitches are dropped silently; every later sample then
    // lands near the middle of its bit.
    always_comb begin
        rx_state_n   = rx_state;
        clk_cnt_n    = clk_cnt;
        bit_cnt_n    = bit_cnt;
        shift_n      = shift;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            R_IDLE: begin
                clk_cnt_n = '0;
                bit_cnt_n = '0;
                if (rx_prev && !rx_s) begin
                    rx_state_n = R_START;
                end
            end
            R_START: begin
                if (clk_cnt == CNT_W'(HALF_BIT - 1)) begin
                    clk_cnt_n  = '0;
                    rx_state_n = rx_s ? R_IDLE : R_DATA;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            R_DATA: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n = '0;
                    shift_n   = {rx_s, shift[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        rx_state_n = R_STOP;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            R_STOP: begin
                if (clk_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    clk_cnt_n    = '0;
                    byte_valid_n = rx_s;
                    frame_err_n  = !rx_s;
                    rx_state_n   = R_IDLE;
                end else begin
                    clk_cnt_n = clk_cnt + 1'b1;
                end
            end
            default: rx_state_n = R_IDLE;
        endcase
    end

    // Loader state register. cpu_rst is simply the inverse of the hold flag,
    // registered alongside it so it changes on the same edge as busy.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ld_state  <= L_SYNC;
            index     <= '0;
            sum       <= '0;
            to_cnt    <= '0;
            hold      <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst   <= 1'b0;
        end else begin
            ld_state  <= ld_state_n;
            index     <= index_n;
            sum       <= sum_n;
            to_cnt    <= to_cnt_n;
            hold      <= hold_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            busy      <= busy_n;
            done      <= done_n;
            err       <= err_n;
            cpu_rst   <= !hold_n;
        end
    end

    // Loader next-state logic. Any failure (bad checksum, framing error or
    // inter-byte timeout) leaves hold set, so the CPU stays in reset over a
    // partially written RAM until a good frame arrives.
    always_comb begin
        ld_state_n  = ld_state;
        index_n     = index;
        sum_n       = sum;
        to_cnt_n    = to_cnt;
        hold_n      = hold;
        mem_we_n    = 1'b0;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        busy_n      = busy;
        done_n      = done;
        err_n       = err;
        case (ld_state)
            L_SYNC: begin
                to_cnt_n = '0;
                if (byte_valid && shift == SYNC_BYTE) begin
                    hold_n     = 1'b1;
                    busy_n     = 1'b1;
                    done_n     = 1'b0;
                    err_n      = 1'b0;
                    index_n    = '0;
                    sum_n      = '0;
                    ld_state_n = L_DATA;
                end
            end
            L_DATA, L_SUM: begin
                if (frame_err || (!byte_valid && to_cnt == TO_W'(TO_LIMIT - 1))) begin
                    err_n      = 1'b1;
                    busy_n     = 1'b0;
                    ld_state_n = L_SYNC;
                end else if (byte_valid) begin
                    to_cnt_n = '0;
                    if (ld_state == L_DATA) begin
                        mem_we_n    = 1'b1;
                        mem_addr_n  = index;
                        mem_wdata_n = shift;
                        sum_n       = sum + shift;
                        index_n     = index + 1'b1;
                        if (index == ADDR_W'(DEPTH - 1)) begin
                            ld_state_n = L_SUM;
                        end
                    end else begin
                        busy_n     = 1'b0;
                        ld_state_n = L_SYNC;
                        if (shift == sum) begin
                            done_n = 1'b1;
                            hold_n = 1'b0;
                        end else begin
                            err_n = 1'b1;
                        end
                    end
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            default: ld_state_n = L_SYNC;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
`timescale 1ns/1ps
// tb_prog_loader
// Drives serial frames into prog_loader with CLKS_PER_BIT=8 and compares the
// observed RAM writes and status flags against a reference built from the
// frame contents: the expected RAM image is the data bytes in order and a
// frame succeeds exactly when its checksum equals their sum mod 256.
module tb_prog_loader;

    localparam int CPB    = 8;
    localparam int TO_CYC = 32 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uart_rx = 1'b1;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_rst, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic [3:0] wr_addr_q [$];
    logic [7:0] wr_data_q [$];
    int         bad_release = 0;
    int         both_flags = 0;
    logic [7:0] frame [16];

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .DEPTH(16),
        .ADDR_W(4),
        .SYNC_BYTE(8'hA5),
        .TIMEOUT_BITS(32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .uart_rx(uart_rx),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_rst(cpu_rst),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    // Record every write strobe and watch invariants on the falling edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
        if (busy && cpu_rst) bad_release++;
        if (done && err) both_flags++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sendBit(input logic b);
        uart_rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    // One 8N1 byte; a bad stop bit is followed by a return to idle.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_ok);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(b[i]);
        sendBit(stop_ok);
        uart_rx = 1'b1;
        repeat (stop_ok ? 2 : 2 * CPB) @(negedge clk);
    endtask

    function automatic logic [7:0] refSum();
        int s;
        s = 0;
        for (int i = 0; i < 16; i++) s += int'(frame[i]);
        return 8'(s % 256);
    endfunction

    task automatic clearWrites();
        wr_addr_q.delete();
        wr_data_q.delete();
        bad_release = 0;
    endtask

    task automatic sendFrame(input string tag, input logic [7:0] cs);
        clearWrites();
        applyStimulus(8'hA5, 1'b1);
        checkOutput({tag, ".busy_after_sync"}, busy, 1);
        checkOutput({tag, ".cpu_held_after_sync"}, cpu_rst, 0);
        for (int i = 0; i < 16; i++) applyStimulus(frame[i], 1'b1);
        checkOutput({tag, ".cpu_held_before_sum"}, cpu_rst, 0);
        applyStimulus(cs, 1'b1);
    endtask

    task automatic checkWrites(input string tag, input int n);
        checkOutput({tag, ".nwrites"}, wr_addr_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < wr_addr_q.size()) begin
                checkOutput($sformatf("%s.addr%0d", tag, i), wr_addr_q[i], i);
                checkOutput($sformatf("%s.data%0d", tag, i), wr_data_q[i], frame[i]);
            end
        end
    endtask

    task automatic checkFrame(input string tag, input logic ok);
        checkWrites(tag, 16);
        checkOutput({tag, ".done"}, done, ok);
        checkOutput({tag, ".err"}, err, !ok);
        checkOutput({tag, ".busy"}, busy, 0);
        checkOutput({tag, ".cpu_rst"}, cpu_rst, ok);
        checkOutput({tag, ".no_early_release"}, bad_release, 0);
    endtask

    task automatic randomFrame();
        for (int i = 0; i < 16; i++) frame[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [7:0] cs;
        logic       good;

        $display("[TB] reset and idle line");
        rst = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("reset.outputs", {mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err}, 0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("reset.cpu_release", cpu_rst, 1);
        repeat (1000) @(negedge clk);
        checkOutput("idle.nwrites", wr_addr_q.size(), 0);
        checkOutput("idle.flags", {busy, done, err}, 0);

        $display("[TB] good frame 00..0F");
        for (int i = 0; i < 16; i++) frame[i] = 8'(i);
        sendFrame("good1", refSum());
        checkFrame("good1", 1'b1);

        $display("[TB] bad checksum then good frame");
        sendFrame("badsum", refSum() - 8'd1);
        checkFrame("badsum", 1'b0);
        randomFrame();
        sendFrame("good2", refSum());
        checkFrame("good2", 1'b1);

        $display("[TB] random frames");
        for (int k = 0; k < 4; k++) begin
            randomFrame();
            if (k == 0) frame[3] = 8'hA5;
            good = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            cs = good ? refSum() : refSum() + 8'($urandom_range(1, 255));
            sendFrame($sformatf("rand%0d", k), cs);
            checkFrame($sformatf("rand%0d", k), good);
        end

        $display("[TB] framing error on sixth frame byte");
        randomFrame();
        clearWrites();
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 5; i++) applyStimulus(frame[i], 1'b1);
        applyStimulus(frame[5], 1'b0);
        checkWrites("frame_err", 5);
        checkOutput("frame_err.flags", {busy, done, err, cpu_rst}, 4'b0010);
        clearWrites();
        applyStimulus(8'h3C, 1'b1);
        checkOutput("noise.nwrites", wr_addr_q.size(), 0);
        checkOutput("noise.flags", {busy, done, err, cpu_rst}, 4'b0010);

        $display("[TB] glitch and timeout");
        randomFrame();
        clearWrites();
        applyStimulus(8'hA5, 1'b1);
        applyStimulus(frame[0], 1'b1);
        applyStimulus(frame[1], 1'b1);
        uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        checkOutput("glitch.nwrites", wr_addr_q.size(), 2);
        checkOutput("glitch.flags", {busy, done, err, cpu_rst}, 4'b1000);
        applyStimulus(frame[2], 1'b1);
        repeat (TO_CYC - 30) @(negedge clk);
        checkOutput("timeout.not_yet", {busy, err}, 2'b10);
        repeat (60) @(negedge clk);
        checkWrites("timeout", 3);
        checkOutput("timeout.flags", {busy, done, err, cpu_rst}, 4'b0010);

        $display("[TB] reset mid-byte");
        randomFrame();
        clearWrites();
        applyStimulus(8'hA5, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(frame[i], 1'b1);
        uart_rx = 1'b0;
        repeat (20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst.outputs", {mem_we, mem_addr, mem_wdata, cpu_rst, busy, done, err}, 0);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst.cpu_release", cpu_rst, 1);
        randomFrame();
        sendFrame("after_rst", refSum());
        checkFrame("after_rst", 1'b1);

        checkOutput("done_err_exclusive", both_flags, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
